// File: rtl/cruise_speed_sequencer.sv
// Arbitrates driver pedals against a cruise sequencer that steps a 4-level speed FSM toward a target.
// All outputs are registered, so pedal-to-output latency is 1 clock. Pedals always win over cruise.
module cruise_speed_sequencer #(
    parameter int DWELL   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       brake_req,
    input  logic       accel_req,
    input  logic       cruise_en,
    input  logic [1:0] target,
    input  logic [1:0] speed,
    output logic       brake,
    output logic       accelerate,
    output logic       busy,
    output logic       at_target,
    output logic       fault
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMP    = 3'd1;
    localparam logic [2:0] S_PULSE  = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_FAULT  = 3'd4;

    localparam logic [CW-1:0] DWELL_M1 = CW'(DWELL - 1);
    localparam logic [CW-1:0] TMO_M1   = CW'(TIMEOUT - 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    tgt_q, tgt_d;
    logic [1:0]    spd_q, spd_d;
    logic          dir_up_q, dir_up_d;
    logic          armed_q, armed_d;
    logic          brake_q, brake_d;
    logic          accel_q, accel_d;
    logic          busy_q, busy_d;
    logic          at_target_q, at_target_d;
    logic          fault_q, fault_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tgt_d    = tgt_q;
        spd_d    = spd_q;
        dir_up_d = dir_up_q;
        armed_d  = armed_q;
        brake_d  = 1'b0;
        accel_d  = 1'b0;

        if (brake_req) begin
            state_d = S_IDLE;
            armed_d = 1'b0;
            brake_d = 1'b1;
        end else if (accel_req) begin
            // Cruise is frozen (state and dwell counter held) while the driver accelerates.
            accel_d = 1'b1;
            if (!cruise_en) begin
                state_d = S_IDLE;
                armed_d = 1'b1;
            end
        end else if (!cruise_en) begin
            state_d = S_IDLE;
            armed_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (armed_q) begin
                        tgt_d   = target;
                        state_d = S_CMP;
                    end
                end
                S_CMP: begin
                    tgt_d = target;
                    if (speed < target) begin
                        dir_up_d = 1'b1;
                        state_d  = S_PULSE;
                    end else if (speed > target) begin
                        dir_up_d = 1'b0;
                        state_d  = S_PULSE;
                    end
                end
                S_PULSE: begin
                    // Guard against a speed that moved to the rail since the compare.
                    if (dir_up_q ? (speed != 2'b11) : (speed != 2'b00)) begin
                        accel_d = dir_up_q;
                        brake_d = !dir_up_q;
                        spd_d   = speed;
                        cnt_d   = '0;
                        state_d = S_SETTLE;
                    end else begin
                        state_d = S_CMP;
                    end
                end
                S_SETTLE: begin
                    if (speed != spd_q && cnt_q >= DWELL_M1) begin
                        state_d = S_CMP;
                    end else if (cnt_q == TMO_M1) begin
                        state_d = S_FAULT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_FAULT: state_d = S_FAULT;
                default: state_d = S_IDLE;
            endcase
        end

        busy_d      = (state_d == S_CMP) || (state_d == S_PULSE) || (state_d == S_SETTLE);
        fault_d     = (state_d == S_FAULT);
        at_target_d = (state_d == S_CMP) && (speed == tgt_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            tgt_q       <= 2'b00;
            spd_q       <= 2'b00;
            dir_up_q    <= 1'b0;
            armed_q     <= 1'b1;
            brake_q     <= 1'b0;
            accel_q     <= 1'b0;
            busy_q      <= 1'b0;
            at_target_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tgt_q       <= tgt_d;
            spd_q       <= spd_d;
            dir_up_q    <= dir_up_d;
            armed_q     <= armed_d;
            brake_q     <= brake_d;
            accel_q     <= accel_d;
            busy_q      <= busy_d;
            at_target_q <= at_target_d;
            fault_q     <= fault_d;
        end
    end

    assign brake      = brake_q;
    assign accelerate = accel_q;
    assign busy       = busy_q;
    assign at_target  = at_target_q;
    assign fault      = fault_q;

endmodule
